capi_command_arbiter: RTL

Shares the single PSL command interface between NUM_REQ accelerator engines, such as the parity work element's request/stripe/parity engines. It tracks PSL command credits and outstanding commands, and stamps each issued command with the requester index in its tag. It routes each PSL response back to the requester that owns it. It sits between the engines and the PSL command/response ports.

---
 rtl/capi_command_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/capi_command_arbiter.sv
// capi_command_arbiter: shares one PSL command port between NUM_REQ engines.
// Round-robin grant gated by PSL credits, requester index stamped in tag[0:1],
// responses routed back by tag[0:1]. Optional parity generation/checking is
// enabled by defining CAPI_ARB_PARITY_EN.
//
// state   | meaning
// S_INIT  | one cycle after reset, load credits from croom
// S_RUN   | grant commands and process responses
// S_DRAIN | no grants, responses still processed until nothing is outstanding
// S_IDLE  | drained; idle=1, drain low returns to S_RUN
module capi_command_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_CREDITS = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [0:7]                    croom,
    input  logic                          drain,
    input  logic [0:NUM_REQ-1]            req_valid,
    input  logic [0:NUM_REQ-1][0:12]      req_command,
    input  logic [0:NUM_REQ-1][0:63]      req_address,
    input  logic [0:NUM_REQ-1][0:11]      req_size,
    input  logic [0:NUM_REQ-1][0:5]       req_tag,
    output logic [0:NUM_REQ-1]            req_ready,
    output logic                          command_valid,
    output logic [0:12]                   command_command,
    output logic [0:63]                   command_address,
    output logic [0:11]                   command_size,
    output logic [0:7]                    command_tag,
    output logic                          command_parity,
    output logic                          address_parity,
    output logic                          tag_parity,
    input  logic                          response_valid,
    input  logic [0:7]                    response_tag,
    input  logic [0:7]                    response_code,
    input  logic                          response_tag_parity,
    output logic [0:NUM_REQ-1]            rsp_valid,
    output logic [0:5]                    rsp_tag,
    output logic [0:7]                    rsp_code,
    output logic [0:7]                    credits,
    output logic [0:7]                    outstanding,
    output logic                          idle,
    output logic                          error
);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN, S_IDLE} state_t;

    localparam logic [7:0] MAX_CRED = 8'(MAX_CREDITS);

    state_t      state;
    logic [1:0]  rr_ptr;
    logic        win_found;
    logic [1:0]  win_idx;
    logic [12:0] win_command;
    logic [63:0] win_address;
    logic [11:0] win_size;
    logic [5:0]  win_tag;
    logic        grant;
    logic [1:0]  rsp_idx;
    logic        rsp_ok;
    logic        rsp_bad;
    logic        parity_bad;
    logic        sat;
    logic [7:0]  out_next;

    // Slot k of the round-robin scan, starting at the pointer and wrapping.
    function automatic int rr_slot(input logic [1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s;
    endfunction

    // Round-robin pick: first valid requester at or after rr_ptr, with its fields.
    always_comb begin
        win_found   = 1'b0;
        win_idx     = 2'd0;
        win_command = '0;
        win_address = '0;
        win_size    = '0;
        win_tag     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_found && req_valid[i] && rr_slot(rr_ptr, k) == i) begin
                    win_found   = 1'b1;
                    win_idx     = 2'(i);
                    win_command = req_command[i];
                    win_address = req_address[i];
                    win_size    = req_size[i];
                    win_tag     = req_tag[i];
                end
            end
        end
    end

    assign grant   = (state == S_RUN) && !drain && (credits != 8'd0) && win_found;
    assign rsp_idx = response_tag[0:1];

    // Responses are only legal for an in-range owner while something is outstanding.
    assign rsp_ok  = response_valid && (int'(rsp_idx) < NUM_REQ) && (outstanding != 8'd0)
                     && ((state == S_RUN) || (state == S_DRAIN));
    assign rsp_bad = response_valid && !rsp_ok;
    assign sat     = rsp_ok && !grant && (credits >= MAX_CRED);

`ifdef CAPI_ARB_PARITY_EN
    assign parity_bad = response_valid && (response_tag_parity != ~^response_tag);
`else
    logic unused_parity;
    assign unused_parity  = response_tag_parity;
    assign parity_bad     = 1'b0;
    assign command_parity = 1'b0;
    assign address_parity = 1'b0;
    assign tag_parity     = 1'b0;
`endif

    // One-hot ready for the winner in the cycle it is accepted.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant && (win_idx == 2'(i));
        end
    end

    // Outstanding count after this cycle; DRAIN uses it to leave on the final response.
    always_comb begin
        out_next = outstanding;
        if (grant && !rsp_ok)      out_next = outstanding + 8'd1;
        else if (rsp_ok && !grant) out_next = outstanding - 8'd1;
    end

    assign idle = (state == S_IDLE);

    // Sequencer, credit/outstanding counters, command and response registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_INIT;
            rr_ptr          <= 2'd0;
            credits         <= 8'd0;
            outstanding     <= 8'd0;
            command_valid   <= 1'b0;
            command_command <= '0;
            command_address <= '0;
            command_size    <= '0;
            command_tag     <= '0;
`ifdef CAPI_ARB_PARITY_EN
            command_parity  <= 1'b1;
            address_parity  <= 1'b1;
            tag_parity      <= 1'b1;
`endif
            rsp_valid       <= '0;
            rsp_tag         <= '0;
            rsp_code        <= '0;
            error           <= 1'b0;
        end else begin
            command_valid <= grant;
            if (grant) begin
                command_command <= win_command;
                command_address <= win_address;
                command_size    <= win_size;
                command_tag     <= {win_idx, win_tag};
`ifdef CAPI_ARB_PARITY_EN
                command_parity  <= ~^win_command;
                address_parity  <= ~^win_address;
                tag_parity      <= ~^{win_idx, win_tag};
`endif
                rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? 2'd0 : win_idx + 2'd1;
            end

            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid[i] <= rsp_ok && (int'(rsp_idx) == i);
            end
            if (rsp_ok) begin
                rsp_tag  <= response_tag[2:7];
                rsp_code <= response_code;
            end

            if (state == S_INIT)           credits <= (croom > MAX_CRED) ? MAX_CRED : croom;
            else if (grant && !rsp_ok)     credits <= credits - 8'd1;
            else if (rsp_ok && !grant && !sat) credits <= credits + 8'd1;
            outstanding <= out_next;

            if (rsp_bad || parity_bad || sat) error <= 1'b1;

            case (state)
                S_INIT:  state <= S_RUN;
                S_RUN:   if (drain) state <= S_DRAIN;
                S_DRAIN: begin
                    if (!drain)                state <= S_RUN;
                    else if (out_next == 8'd0) state <= S_IDLE;
                end
                S_IDLE:  if (!drain) state <= S_RUN;
                default: state <= S_INIT;
            endcase
        end
    end

endmodule
